irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 17 +
 rtl/irq_sync.sv | 48 ++++
 rtl/irq_ctrl.sv | 136 +++++++++++++
 tb/tb_irq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// register addresses and the "no source in service" marker.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    localparam logic [1:0] ADR_MASK  = 2'd0;
    localparam logic [1:0] ADR_PEND  = 2'd1;
    localparam logic [1:0] ADR_INSVC = 2'd2;

    localparam logic [7:0] INSVC_NONE = 8'hFF;

endpackage

// File: rtl/irq_sync.sv
// Per-source input conditioning: 2-FF synchronizer, and with
// IRQ_CTRL_EDGE_EN defined a rising-edge detector behind it.
// Without the macro the synchronized level itself is the trigger.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic trig
);

    logic meta;
    logic sync;

`ifdef IRQ_CTRL_EDGE_EN
    logic prev;

    // Two synchronizer stages plus the previous synchronized value for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the pre-edge value of the one before it
            meta <= src;
            sync <= meta;
            prev <= sync;
        end
    end

    assign trig = sync & ~prev;
`else
    // Two synchronizer stages; the synchronized level triggers every cycle it is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the pre-edge value of the one before it
            meta <= src;
            sync <= meta;
        end
    end

    assign trig = sync;
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: NUM_IRQ synchronized sources latch into PEND,
// the lowest-index pending-and-enabled source wins, and an
// IDLE/REQ/SVC handshake with the CPU (intack, rti) drives irq and insvc.
// Optional build macro IRQ_CTRL_EDGE_EN selects edge-triggered sources
// (default build: level-triggered).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] src,
    output logic               irq,
    input  logic               intack,
    input  logic               rti,
    input  logic               io_wr,
    input  logic               io_rd,
    input  logic [1:0]         io_adr,
    input  logic [31:0]        io_din,
    output logic [31:0]        io_dout,
    output logic [7:0]         insvc
);

    state_t             state;
    logic [NUM_IRQ-1:0] trig;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] sw_clr;
    logic [NUM_IRQ-1:0] ack_clr;
    logic               has_win;
    logic [7:0]         win;

    // Reads have no side effects, so the read strobe is not needed
    logic unused;
    assign unused = ^{io_rd, io_din};

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .src  (src[i]),
            .trig (trig[i])
        );
    end

    assign active = pend & mask;

    // Priority encoder: scan high to low so the lowest active index is kept
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch
        has_win = 1'b0;
        win     = INSVC_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                has_win = 1'b1;
                win     = 8'(i);
            end
        end
    end

    // Pending-bit clear sources: software write-1-to-clear and the acknowledged winner
    always_comb begin
        sw_clr  = '0;
        ack_clr = '0;
        if (io_wr && io_adr == ADR_PEND) begin
            sw_clr = io_din[NUM_IRQ-1:0];
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = (state == ST_REQ) && intack && has_win && (win == 8'(i));
        end
    end

    // MASK and PEND registers; a trigger in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= '0;
            pend <= '0;
        end else begin
            if (io_wr && io_adr == ADR_MASK) begin
                mask <= io_din[NUM_IRQ-1:0];
            end
            pend <= (pend & ~(sw_clr | ack_clr)) | trig;
        end
    end

    // Handshake FSM with registered irq and insvc
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
            insvc <= INSVC_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|active) begin
                        state <= ST_REQ;
                        irq   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Winner is re-evaluated here; it may have been cleared or masked meanwhile
                    if (intack) begin
                        state <= ST_SVC;
                        irq   <= 1'b0;
                        insvc <= has_win ? win : INSVC_NONE;
                    end
                end
                ST_SVC: begin
                    if (rti) begin
                        state <= ST_IDLE;
                        insvc <= INSVC_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                    insvc <= INSVC_NONE;
                end
            endcase
        end
    end

    // Register read mux, combinational from the address
    always_comb begin
        io_dout = '0;
        case (io_adr)
            ADR_MASK:  io_dout = 32'(mask);
            ADR_PEND:  io_dout = 32'(pend);
            ADR_INSVC: io_dout = {24'd0, insvc};
            default:   io_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are sampled there too, away from the edge.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int NUM_IRQ = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] src;
    logic               irq;
    logic               intack;
    logic               rti;
    logic               io_wr;
    logic               io_rd;
    logic [1:0]         io_adr;
    logic [31:0]        io_din;
    logic [31:0]        io_dout;
    logic [7:0]         insvc;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .src     (src),
        .irq     (irq),
        .intack  (intack),
        .rti     (rti),
        .io_wr   (io_wr),
        .io_rd   (io_rd),
        .io_adr  (io_adr),
        .io_din  (io_din),
        .io_dout (io_dout),
        .insvc   (insvc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] adr, input logic [31:0] d);
        io_wr  = 1'b1;
        io_adr = adr;
        io_din = d;
        tick();
        io_wr  = 1'b0;
        io_din = '0;
    endtask

    task automatic reg_read(input logic [1:0] adr, output logic [31:0] d);
        io_adr = adr;
        io_rd  = 1'b1;
        #1;
        d      = io_dout;
        io_rd  = 1'b0;
    endtask

    task automatic pulse_src(input logic [NUM_IRQ-1:0] m);
        src = m;
        tick();
        src = '0;
    endtask

    task automatic do_ack();
        intack = 1'b1;
        tick();
        intack = 1'b0;
    endtask

    task automatic do_rti();
        rti = 1'b1;
        tick();
        rti = 1'b0;
    endtask

    task automatic wait_irq(input int max, output int cycles);
        cycles = 0;
        while (!irq && cycles < max) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b0; src = '0; intack = 0; rti = 0; io_wr = 0; io_rd = 0; io_adr = 0; io_din = 0;
        #12;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0h expected 0", irq); end
        checks++; if (insvc !== INSVC_NONE) begin errors++; $display("FAIL reset_insvc: got %0h expected ff", insvc); end
        reg_read(ADR_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %0h expected 0", d); end
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend: got %0h expected 0", d); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_regmap();
        logic [31:0] d;
        reg_write(ADR_MASK, 32'hFFFF_FFFF);
        reg_read(ADR_MASK, d);
        checks++; if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL regmap_mask_upper: got %0h expected ffff", d); end
        reg_write(2'd3, 32'h1234_5678);
        reg_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL regmap_adr3: got %0h expected 0", d); end
        reg_read(ADR_INSVC, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL regmap_insvc: got %0h expected ff", d); end
        reg_write(ADR_MASK, 32'h0);
    endtask

    task automatic test_single();
        logic [31:0] d;
        int cyc;
        reg_write(ADR_MASK, 32'h0004);
        pulse_src(16'h0004);
        wait_irq(3, cyc);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq_latency: got irq %0h after %0d cycles expected 1 within 4", irq, cyc + 1); end
        // rti while requesting must be ignored
        do_rti();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_rti_in_req: got %0h expected 1", irq); end
        do_ack();
        checks++; if (insvc !== 8'd2) begin errors++; $display("FAIL single_insvc: got %0h expected 2", insvc); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_drop: got %0h expected 0", irq); end
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_pend_clr: got %0h expected 0", d); end
        reg_read(ADR_INSVC, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL single_insvc_reg: got %0h expected 2", d); end
        do_rti();
        checks++; if (insvc !== INSVC_NONE) begin errors++; $display("FAIL single_rti: got %0h expected ff", insvc); end
    endtask

    task automatic test_ignored();
        do_ack();
        checks++; if (irq !== 1'b0 || insvc !== INSVC_NONE) begin errors++; $display("FAIL ignored_intack: got irq %0h insvc %0h expected 0 ff", irq, insvc); end
        do_rti();
        tick();
        checks++; if (irq !== 1'b0 || insvc !== INSVC_NONE) begin errors++; $display("FAIL ignored_rti: got irq %0h insvc %0h expected 0 ff", irq, insvc); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        int cyc;
        reg_write(ADR_MASK, 32'hFFFF);
        pulse_src(16'h0028);
        wait_irq(6, cyc);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq: got %0h expected 1", irq); end
        do_ack();
        checks++; if (insvc !== 8'd3) begin errors++; $display("FAIL prio_first: got %0h expected 3", insvc); end
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h20) begin errors++; $display("FAIL prio_pend_left: got %0h expected 20", d); end
        do_rti();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_idle_gap: got %0h expected 0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_reraise: got %0h expected 1", irq); end
        do_ack();
        checks++; if (insvc !== 8'd5) begin errors++; $display("FAIL prio_second: got %0h expected 5", insvc); end
        do_rti();
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        int cyc;
        pulse_src(16'h0004);
        wait_irq(6, cyc);
        reg_write(ADR_PEND, 32'h0004);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL spur_irq_held: got %0h expected 1", irq); end
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL spur_pend_clr: got %0h expected 0", d); end
        do_ack();
        checks++; if (insvc !== INSVC_NONE) begin errors++; $display("FAIL spur_insvc: got %0h expected ff", insvc); end
        do_rti();
    endtask

    task automatic test_mask_in_req();
        logic [31:0] d;
        int cyc;
        pulse_src(16'h0010);
        wait_irq(6, cyc);
        reg_write(ADR_MASK, 32'h0);
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL maskreq_irq_held: got %0h expected 1", irq); end
        do_ack();
        checks++; if (insvc !== INSVC_NONE) begin errors++; $display("FAIL maskreq_insvc: got %0h expected ff", insvc); end
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL maskreq_pend_kept: got %0h expected 10", d); end
        reg_write(ADR_PEND, 32'h10);
        do_rti();
        reg_write(ADR_MASK, 32'hFFFF);
    endtask

    task automatic test_collision();
        logic [31:0] d;
        int cyc;
        pulse_src(16'h0002);
        wait_irq(6, cyc);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq: got %0h expected 1", irq); end
        // Second pulse: its synchronized trigger lands in the intack cycle
        pulse_src(16'h0002);
        tick();
        do_ack();
        checks++; if (insvc !== 8'd1) begin errors++; $display("FAIL coll_insvc: got %0h expected 1", insvc); end
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL coll_pend_kept: got %0h expected 2", d); end
        do_rti();
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_reraise: got %0h expected 1", irq); end
        do_ack();
        do_rti();
    endtask

    task automatic test_reset_in_svc();
        logic [31:0] d;
        int cyc;
        pulse_src(16'h0040);
        wait_irq(6, cyc);
        do_ack();
        checks++; if (insvc !== 8'd6) begin errors++; $display("FAIL rstsvc_insvc_pre: got %0h expected 6", insvc); end
        rst = 1'b0;
        #1;
        checks++; if (irq !== 1'b0 || insvc !== INSVC_NONE) begin errors++; $display("FAIL rstsvc_async: got irq %0h insvc %0h expected 0 ff", irq, insvc); end
        reg_read(ADR_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstsvc_mask: got %0h expected 0", d); end
        tick();
        rst = 1'b1;
        pulse_src(16'h0040);
        repeat (5) tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstsvc_no_irq: got %0h expected 0", irq); end
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL rstsvc_pend: got %0h expected 40", d); end
        reg_write(ADR_MASK, 32'h0040);
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstsvc_irq_after_mask: got %0h expected 1", irq); end
        do_ack();
        checks++; if (insvc !== 8'd6) begin errors++; $display("FAIL rstsvc_insvc_post: got %0h expected 6", insvc); end
        do_rti();
    endtask

    task automatic test_mode();
        logic [31:0] d;
        int cyc;
        int services = 0;
        int expected;
`ifdef IRQ_CTRL_EDGE_EN
        expected = 1;
`else
        expected = 3;
`endif
        reg_write(ADR_MASK, 32'h0001);
        src = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            wait_irq(8, cyc);
            if (irq) begin
                services++;
                do_ack();
                do_rti();
            end
        end
        src = '0;
        repeat (3) tick();
        reg_write(ADR_PEND, 32'h0001);
        if (irq) begin
            do_ack();
            do_rti();
        end
        checks++; if (services !== expected) begin errors++; $display("FAIL mode_services: got %0d expected %0d", services, expected); end
        tick();
        reg_read(ADR_PEND, d);
        checks++; if (d !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL mode_cleanup: got pend %0h irq %0h expected 0 0", d, irq); end
    endtask

    initial begin
        test_reset();
        test_regmap();
        test_single();
        test_ignored();
        test_priority();
        test_spurious();
        test_mask_in_req();
        test_collision();
        test_reset_in_svc();
        test_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
